// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
// The arbiter connects through slave; the requesters and memory connect through master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rdata, if_valid, d_gnt, d_rdata, d_valid,
               mem_addr, mem_wdata, mem_we, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rdata, if_valid, d_gnt, d_rdata, d_valid,
               mem_addr, mem_wdata, mem_we, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data access.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating grants on contention; default is data priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          own_d;
    logic          we_q;
    logic          pick_d;
    logic          rd_done;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d;
    assign pick_d = bus.d_req && (!bus.if_req || !last_d);
`else
    assign pick_d = bus.d_req;
`endif

    // Last cycle the memory is addressed for a read; rdata is captured on its closing edge.
    assign rd_done = (state == ISSUE && !we_q && RD_LAT == 1) ||
                     (state == WAIT && cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            own_d         <= 1'b0;
            we_q          <= 1'b0;
            bus.if_gnt    <= 1'b0;
            bus.d_gnt     <= 1'b0;
            bus.if_valid  <= 1'b0;
            bus.d_valid   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
            bus.busy      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d        <= 1'b0;
`endif
        end else begin
            bus.if_gnt   <= 1'b0;
            bus.d_gnt    <= 1'b0;
            bus.if_valid <= 1'b0;
            bus.d_valid  <= 1'b0;
            bus.mem_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        state    <= ISSUE;
                        bus.busy <= 1'b1;
                        own_d    <= pick_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_d   <= pick_d;
`endif
                        if (pick_d) begin
                            bus.d_gnt     <= 1'b1;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                            bus.mem_we    <= bus.d_we;
                            we_q          <= bus.d_we;
                        end else begin
                            bus.if_gnt    <= 1'b1;
                            bus.mem_addr  <= bus.if_addr;
                            we_q          <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        state       <= DONE;
                        bus.d_valid <= 1'b1;
                    end else if (rd_done) begin
                        state <= DONE;
                        if (own_d) begin
                            bus.d_rdata <= bus.mem_rdata;
                            bus.d_valid <= 1'b1;
                        end else begin
                            bus.if_rdata <= bus.mem_rdata;
                            bus.if_valid <= 1'b1;
                        end
                    end else begin
                        state <= WAIT;
                        cnt   <= CW'(RD_LAT - 1);
                    end
                end
                WAIT: begin
                    if (rd_done) begin
                        state <= DONE;
                        if (own_d) begin
                            bus.d_rdata <= bus.mem_rdata;
                            bus.d_valid <= 1'b1;
                        end else begin
                            bus.if_rdata <= bus.mem_rdata;
                            bus.if_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: RD_LAT=2 instance for most cases, RD_LAT=1 instance for the no-WAIT load.
module tb_mem_port_arbiter;
    localparam int IGNT = 0, DGNT = 1, WE = 2, IVAL = 3, DVAL = 4;

    typedef struct {
        int          cyc;
        int          code;
        logic [63:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   vec = 0;
    int   err = 0;
    ev_t  q0[$];
    ev_t  q1[$];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) dut0 (.clk(clk), .reset(reset), .bus(a));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(b));

    function automatic logic [31:0] memf(input logic [31:0] addr);
        case (addr)
            32'h40:  return 32'h00500093;
            32'h8:   return 32'hCAFEF00D;
            default: return {addr[15:0], 16'hC0DE};
        endcase
    endfunction

    assign a.mem_rdata = memf(a.mem_addr);
    assign b.mem_rdata = memf(b.mem_addr);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string nm(input int c);
        case (c)
            IGNT:    return "if_gnt";
            DGNT:    return "d_gnt";
            WE:      return "mem_we";
            IVAL:    return "if_valid";
            default: return "d_valid";
        endcase
    endfunction

    task automatic push(input int d, input int c, input int code, input logic [63:0] data);
        ev_t e;
        e.cyc = c; e.code = code; e.data = data;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic obs(input int d, input int code, input logic [63:0] data);
        ev_t e;
        vec++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            err++;
            $display("FAIL dut%0d unexpected %s at cycle %0d data %h (nothing expected)", d, nm(code), cyc, data);
        end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            if (e.cyc != cyc || e.code != code || e.data !== data) begin
                err++;
                $display("FAIL dut%0d event: got %s cyc %0d data %h, expected %s cyc %0d data %h",
                         d, nm(code), cyc, data, nm(e.code), e.cyc, e.data);
            end
        end
    endtask

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the head of that instance's queue.
    always @(negedge clk) begin
        if (a.if_gnt   === 1'b1) obs(0, IGNT, {32'h0, a.mem_addr});
        if (a.d_gnt    === 1'b1) obs(0, DGNT, {32'h0, a.mem_addr});
        if (a.mem_we   === 1'b1) obs(0, WE,   {a.mem_addr, a.mem_wdata});
        if (a.if_valid === 1'b1) obs(0, IVAL, {32'h0, a.if_rdata});
        if (a.d_valid  === 1'b1) obs(0, DVAL, {32'h0, a.d_rdata});
        if (b.if_gnt   === 1'b1) obs(1, IGNT, {32'h0, b.mem_addr});
        if (b.d_gnt    === 1'b1) obs(1, DGNT, {32'h0, b.mem_addr});
        if (b.mem_we   === 1'b1) obs(1, WE,   {b.mem_addr, b.mem_wdata});
        if (b.if_valid === 1'b1) obs(1, IVAL, {32'h0, b.if_rdata});
        if (b.d_valid  === 1'b1) obs(1, DVAL, {32'h0, b.d_rdata});
    end

    task automatic nx();
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic own_d;
        a.if_req = 0; a.if_addr = 0; a.d_req = 0; a.d_we = 0; a.d_addr = 0; a.d_wdata = 0;
        b.if_req = 0; b.if_addr = 0; b.d_req = 0; b.d_we = 0; b.d_addr = 0; b.d_wdata = 0;
        repeat (3) nx();
        chk("rst_busy", {63'h0, a.busy}, 64'h0);
        chk("rst_outs", {58'h0, a.if_gnt, a.d_gnt, a.if_valid, a.d_valid, a.mem_we, b.busy}, 64'h0);
        chk("rst_mem_addr", {32'h0, a.mem_addr}, 64'h0);
        chk("rst_mem_wdata", {32'h0, a.mem_wdata}, 64'h0);
        chk("rst_rdata", {a.if_rdata, a.d_rdata}, 64'h0);
        reset = 0;
        nx();

        // Fetch at 0x40
        n = cyc; a.if_addr = 32'h40; a.if_req = 1;
        push(0, n + 1, IGNT, 64'h40);
        push(0, n + 3, IVAL, 64'h00500093);
        nx(); a.if_req = 0;
        chk("fetch_addr_n1", {32'h0, a.mem_addr}, 64'h40);
        chk("fetch_busy_n1", {63'h0, a.busy}, 64'h1);
        nx(); chk("fetch_addr_n2", {32'h0, a.mem_addr}, 64'h40);
        nx();
        nx(); chk("fetch_busy_n4", {63'h0, a.busy}, 64'h0);

        // Store 0xDEADBEEF to 0x100; d_rdata still holds its reset value
        n = cyc; a.d_req = 1; a.d_we = 1; a.d_addr = 32'h100; a.d_wdata = 32'hDEADBEEF;
        push(0, n + 1, DGNT, 64'h100);
        push(0, n + 1, WE, {32'h100, 32'hDEADBEEF});
        push(0, n + 2, DVAL, 64'h0);
        nx(); a.d_req = 0; a.d_we = 0;
        nx(); chk("store_busy_n2", {63'h0, a.busy}, 64'h1);
        nx(); chk("store_busy_n3", {63'h0, a.busy}, 64'h0);

        // Reset so the first contention sees the reset last-owner flag
        reset = 1; nx(); nx(); reset = 0;

        // Contention: both held for four transactions
        n = cyc; a.if_addr = 32'h40; a.d_addr = 32'h200; a.d_we = 0;
        a.if_req = 1; a.d_req = 1;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            own_d = (k % 2 == 0);
`else
            own_d = 1'b1;
`endif
            if (own_d) begin
                push(0, n + 1 + 4 * k, DGNT, 64'h200);
                push(0, n + 3 + 4 * k, DVAL, 64'h0200C0DE);
            end else begin
                push(0, n + 1 + 4 * k, IGNT, 64'h40);
                push(0, n + 3 + 4 * k, IVAL, 64'h00500093);
            end
        end
        repeat (13) nx();
        a.if_req = 0; a.d_req = 0;
        repeat (3) nx();
        chk("cont_busy_end", {63'h0, a.busy}, 64'h0);

        // Reset during WAIT of a load at 0x300: no d_valid, outputs cleared
        n = cyc; a.d_req = 1; a.d_addr = 32'h300;
        push(0, n + 1, DGNT, 64'h300);
        nx(); a.d_req = 0;
        nx(); reset = 1;
        nx();
        chk("rstw_busy", {63'h0, a.busy}, 64'h0);
        chk("rstw_mem_addr", {32'h0, a.mem_addr}, 64'h0);
        chk("rstw_rdata", {a.if_rdata, a.d_rdata}, 64'h0);
        chk("rstw_pulses", {59'h0, a.if_gnt, a.d_gnt, a.if_valid, a.d_valid, a.mem_we}, 64'h0);
        reset = 0;
        repeat (4) nx();

        // Load 0x8 with d_req dropped the cycle after d_gnt
        n = cyc; a.d_req = 1; a.d_addr = 32'h8;
        push(0, n + 1, DGNT, 64'h8);
        push(0, n + 3, DVAL, 64'hCAFEF00D);
        nx(); nx(); a.d_req = 0;
        nx(); nx();
        chk("drop_busy_n4", {63'h0, a.busy}, 64'h0);

        // RD_LAT=1 load of 0x8: no WAIT
        n = cyc; b.d_req = 1; b.d_addr = 32'h8;
        push(1, n + 1, DGNT, 64'h8);
        push(1, n + 2, DVAL, 64'hCAFEF00D);
        nx(); b.d_req = 0;
        chk("lat1_addr_n1", {32'h0, b.mem_addr}, 64'h8);
        nx(); chk("lat1_busy_n2", {63'h0, b.busy}, 64'h1);
        nx(); chk("lat1_busy_n3", {63'h0, b.busy}, 64'h0);

        repeat (3) nx();
        chk("q0_drained", 64'(q0.size()), 64'h0);
        chk("q1_drained", 64'(q1.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
